// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing light controller: timed car/ped phases, latched walk
// request with minimum car green, and a flashing night mode.
module ped_crossing_ctrl #(
  parameter int CNT_W      = 8,
  parameter int GREEN_MIN  = 10,
  parameter int YELLOW_T   = 3,
  parameter int ALL_RED_T  = 2,
  parameter int WALK_T     = 8,
  parameter int CLEAR_T    = 6,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       night,
  output logic [2:0] car_lights,
  output logic [1:0] ped_lights,
  output logic [2:0] state_o,
  output logic       req_pending
);

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED    = 3'd2,
    PED_WALK   = 3'd3,
    PED_CLEAR  = 3'd4,
    NIGHT      = 3'd5
  } state_t;

  localparam int FLASH_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]   GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0]   YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0]   RED_LAST    = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0]   WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0]   CLEAR_LAST  = CNT_W'(CLEAR_T - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST  = FLASH_W'(2 * FLASH_HALF - 1);
  localparam logic [FLASH_W-1:0] FLASH_ON_LT = FLASH_W'(FLASH_HALF);

  state_t             state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nx_s, cnt_lim_s;
  logic [FLASH_W-1:0] flash_r, flash_nx_s;
  logic               req_r, req_nx_s;
  logic               change_s, flash_on_s;

  // Next-state selection and per-state saturation limit of the phase counter.
  always_comb begin
    state_nx_s = state_r;
    cnt_lim_s  = {CNT_W{1'b0}};
    case (state_r)
      CAR_GREEN: begin
        cnt_lim_s = GREEN_LAST;
        if ((cnt_r == GREEN_LAST) && (req_r || night)) state_nx_s = CAR_YELLOW;
        else state_nx_s = CAR_GREEN;
      end
      CAR_YELLOW: begin
        cnt_lim_s = YELLOW_LAST;
        if (cnt_r == YELLOW_LAST) state_nx_s = ALL_RED;
        else state_nx_s = CAR_YELLOW;
      end
      ALL_RED: begin
        cnt_lim_s = RED_LAST;
        if (cnt_r != RED_LAST) state_nx_s = ALL_RED;
        else if (night)        state_nx_s = NIGHT;
        else if (req_r)        state_nx_s = PED_WALK;
        else                   state_nx_s = CAR_GREEN;
      end
      PED_WALK: begin
        cnt_lim_s = WALK_LAST;
        if (cnt_r == WALK_LAST) state_nx_s = PED_CLEAR;
        else state_nx_s = PED_WALK;
      end
      PED_CLEAR: begin
        cnt_lim_s = CLEAR_LAST;
        if (cnt_r == CLEAR_LAST) state_nx_s = CAR_GREEN;
        else state_nx_s = PED_CLEAR;
      end
      NIGHT: begin
        cnt_lim_s = {CNT_W{1'b0}};
        if (night) state_nx_s = NIGHT;
        else state_nx_s = ALL_RED;
      end
      default: begin
        cnt_lim_s  = {CNT_W{1'b0}};
        state_nx_s = CAR_GREEN;
      end
    endcase
  end

  // Counters restart on every state change; a press made on the edge that
  // enters PED_WALK is cleared together with the served request.
  always_comb begin
    change_s   = (state_nx_s != state_r);
    cnt_nx_s   = cnt_r;
    flash_nx_s = flash_r;
    req_nx_s   = req_r;
    if (change_s) begin
      cnt_nx_s   = {CNT_W{1'b0}};
      flash_nx_s = {FLASH_W{1'b0}};
    end else begin
      if (cnt_r == cnt_lim_s) cnt_nx_s = cnt_r;
      else cnt_nx_s = cnt_r + 1'b1;
      if (flash_r == FLASH_LAST) flash_nx_s = {FLASH_W{1'b0}};
      else flash_nx_s = flash_r + 1'b1;
    end
    if (change_s && ((state_nx_s == PED_WALK) || (state_nx_s == NIGHT)))
      req_nx_s = 1'b0;
    else if (button && ((state_r == CAR_GREEN) || (state_r == CAR_YELLOW) ||
                        (state_r == ALL_RED)))
      req_nx_s = 1'b1;
    else
      req_nx_s = req_r;
  end

  // State, phase, flash and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CAR_GREEN;
      cnt_r   <= {CNT_W{1'b0}};
      flash_r <= {FLASH_W{1'b0}};
      req_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      flash_r <= flash_nx_s;
      req_r   <= req_nx_s;
    end
  end

  // Lamp decode; unknown codes show all-red for the single cycle they exist.
  always_comb begin
    flash_on_s = (flash_r < FLASH_ON_LT);
    car_lights = 3'b100;
    ped_lights = 2'b01;
    case (state_r)
      CAR_GREEN:  begin car_lights = 3'b001; ped_lights = 2'b01; end
      CAR_YELLOW: begin car_lights = 3'b010; ped_lights = 2'b01; end
      ALL_RED:    begin car_lights = 3'b100; ped_lights = 2'b01; end
      PED_WALK:   begin car_lights = 3'b100; ped_lights = 2'b10; end
      PED_CLEAR:  begin car_lights = 3'b100; ped_lights = {1'b0, flash_on_s}; end
      NIGHT:      begin car_lights = {1'b0, flash_on_s, 1'b0}; ped_lights = 2'b00; end
      default:    begin car_lights = 3'b100; ped_lights = 2'b01; end
    endcase
  end

  assign state_o     = state_r;
  assign req_pending = req_r;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl: directed scenarios plus random
// button/night/reset traffic, all checked against a phase/age reference model.
module tb_ped_crossing_ctrl;

  localparam int GREEN_MIN  = 10;
  localparam int YELLOW_T   = 3;
  localparam int ALL_RED_T  = 2;
  localparam int WALK_T     = 8;
  localparam int CLEAR_T    = 6;
  localparam int FLASH_HALF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button = 1'b0;
  logic       night = 1'b0;
  logic [2:0] car_lights;
  logic [1:0] ped_lights;
  logic [2:0] state_o;
  logic       req_pending;

  ped_crossing_ctrl #(
    .CNT_W(8), .GREEN_MIN(GREEN_MIN), .YELLOW_T(YELLOW_T), .ALL_RED_T(ALL_RED_T),
    .WALK_T(WALK_T), .CLEAR_T(CLEAR_T), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .night(night),
    .car_lights(car_lights), .ped_lights(ped_lights),
    .state_o(state_o), .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int car;
    int ped;
    int req;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: phase number, cycles spent in the phase, request flag.
  int m_ph  = 0;
  int m_age = 0;
  int m_req = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit b, input bit n, input bit r);
    int nph;
    if (r) begin
      m_ph = 0; m_age = 0; m_req = 0;
    end else begin
      nph = m_ph;
      case (m_ph)
        0: if (m_age >= GREEN_MIN - 1 && (m_req != 0 || n)) nph = 1;
        1: if (m_age == YELLOW_T - 1) nph = 2;
        2: if (m_age == ALL_RED_T - 1) nph = n ? 5 : (m_req != 0 ? 3 : 0);
        3: if (m_age == WALK_T - 1) nph = 4;
        4: if (m_age == CLEAR_T - 1) nph = 0;
        5: if (!n) nph = 2;
        default: nph = 0;
      endcase
      if (b && m_ph <= 2) m_req = 1;
      if (nph != m_ph && (nph == 3 || nph == 5)) m_req = 0;
      m_age = (nph != m_ph) ? 0 : m_age + 1;
      m_ph  = nph;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   f;
    f = ((m_age % (2 * FLASH_HALF)) < FLASH_HALF) ? 1 : 0;
    e.st  = m_ph;
    e.req = m_req;
    case (m_ph)
      0: begin e.car = 3'b001; e.ped = 2'b01; end
      1: begin e.car = 3'b010; e.ped = 2'b01; end
      2: begin e.car = 3'b100; e.ped = 2'b01; end
      3: begin e.car = 3'b100; e.ped = 2'b10; end
      4: begin e.car = 3'b100; e.ped = f; end
      default: begin e.car = f * 2; e.ped = 0; end
    endcase
    return e;
  endfunction

  // One cycle of stimulus: drive inputs mid-cycle and queue what the DUT must
  // show after the coming rising edge. On return the DUT still shows the
  // current cycle, so directed checks right after a call observe that cycle.
  task automatic step(input bit b, input bit n, input bit r);
    @(negedge clk);
    button = b; night = n; reset = r;
    model_step(b, n, r);
    exp_q.push_back(model_out());
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("state_o", state_o, mon_e.st);
      chk("car_lights", car_lights, mon_e.car);
      chk("ped_lights", ped_lights, mon_e.ped);
      chk("req_pending", req_pending, mon_e.req);
    end
  end

  initial begin
    bit nt;
    // Served request from a single press at cycle 3.
    step(0, 0, 1);
    for (int c = 0; c < 36; c++) begin
      step(c == 3, 0, 0);
      if (c == 3)  chk("s1_req_before", req_pending, 0);
      if (c == 4)  chk("s1_req_latched", req_pending, 1);
      if (c == 9)  chk("s1_green_last", state_o, 0);
      if (c == 10) chk("s1_yellow", state_o, 1);
      if (c == 13) chk("s1_all_red", state_o, 2);
      if (c == 15) chk("s1_walk", state_o, 3);
      if (c == 23) chk("s1_clear_dw", ped_lights, 2'b01);
      if (c == 25) chk("s1_clear_dw_off", ped_lights, 2'b00);
      if (c == 29) chk("s1_green_back", state_o, 0);
      if (c == 29) chk("s1_req_cleared", req_pending, 0);
    end

    // Long idle green, late press served immediately.
    step(0, 0, 1);
    for (int c = 0; c < 56; c++) begin
      step(c == 50, 0, 0);
      if (c == 50) chk("s2_idle_green", car_lights, 3'b001);
      if (c == 51) chk("s2_req", req_pending, 1);
      if (c == 52) chk("s2_yellow", state_o, 1);
    end

    // Button held throughout: no second latch until back in green.
    step(0, 0, 1);
    for (int c = 0; c < 32; c++) begin
      step(1, 0, 0);
      if (c == 15) chk("s3_walk_req", req_pending, 0);
      if (c == 29) chk("s3_green_req0", req_pending, 0);
      if (c == 30) chk("s3_relatch", req_pending, 1);
    end

    // Night from cycle 0, then dropped at cycle 25.
    step(0, 0, 1);
    for (int c = 0; c < 32; c++) begin
      step(0, c < 25, 0);
      if (c == 10) chk("s4_yellow", state_o, 1);
      if (c == 15) chk("s4_night", state_o, 5);
      if (c == 15) chk("s4_flash_on", car_lights, 3'b010);
      if (c == 17) chk("s4_flash_off", car_lights, 3'b000);
      if (c == 19) chk("s4_flash_on2", car_lights, 3'b010);
      if (c == 16) chk("s4_ped_dark", ped_lights, 2'b00);
      if (c == 27) chk("s4_all_red", state_o, 2);
      if (c == 28) chk("s4_green", state_o, 0);
    end

    // Night raised during walk does not abort the crossing.
    step(0, 0, 1);
    for (int c = 0; c < 46; c++) begin
      step(c == 3, c >= 17, 0);
      if (c == 23) chk("s5_clear", state_o, 4);
      if (c == 38) chk("s5_green_hold", state_o, 0);
      if (c == 39) chk("s5_yellow", state_o, 1);
      if (c == 44) chk("s5_night", state_o, 5);
    end

    // Reset in the 4th walk cycle.
    step(0, 0, 1);
    for (int c = 0; c < 21; c++) begin
      step(c == 3, 0, c == 18);
      if (c == 18) chk("s6_walk", state_o, 3);
      if (c == 19) chk("s6_state", state_o, 0);
      if (c == 19) chk("s6_car", car_lights, 3'b001);
      if (c == 19) chk("s6_ped", ped_lights, 2'b01);
      if (c == 19) chk("s6_req", req_pending, 0);
    end

    // Random traffic.
    step(0, 0, 1);
    nt = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 79) == 0) nt = ~nt;
      step($urandom_range(0, 11) == 0, nt, $urandom_range(0, 499) == 0);
    end

    step(0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
